iopage_ctl: RTL and testbench

CPU-side initiator for the I/O-page register bus. It turns single CPU register requests into iopage_rd/iopage_wr cycles toward the device register blocks, steers the returned data from whichever device claims the address, and reports non-existent-memory (NXM) when no device claims it within a timeout. It also arbitrates device interrupt requests, presents one vector to the CPU, and returns a per-device acknowledge.

---
 rtl/iopage_ctl_pkg.sv | 31 +++
 rtl/iopage_int_arb.sv | 81 ++++++++
 rtl/iopage_ctl.sv | 132 +++++++++++++
 tb/tb_iopage_ctl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iopage_ctl_pkg.sv
// Shared widths, FSM encodings and read-data steering for the I/O-page initiator.
package iopage_ctl_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned VEC_W  = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_STROBE,
    BUS_DONE,
    BUS_NXM
  } bus_state_t;

  typedef enum logic [1:0] {
    INT_IDLE,
    INT_PEND,
    INT_ACK
  } int_state_t;

  // Byte reads return the addressed byte right-justified; word reads pass through.
  function automatic logic [DATA_W-1:0] steer_rd(input logic [DATA_W-1:0] word,
                                                 input logic byte_op,
                                                 input logic hi);
    if (!byte_op) return word;
    return hi ? {BYTE_W'(0), word[DATA_W-1:BYTE_W]} : {BYTE_W'(0), word[BYTE_W-1:0]};
  endfunction

endpackage

// File: rtl/iopage_int_arb.sv
// Fixed-priority interrupt arbiter: latches one winner and its vector until ack or withdrawal.
module iopage_int_arb
  import iopage_ctl_pkg::*;
#(
  parameter int unsigned NDEV = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NDEV-1:0]         dev_interrupt,
  input  logic [VEC_W*NDEV-1:0]   dev_vector,
  input  logic                    cpu_int_ack,
  output logic [NDEV-1:0]         dev_interrupt_ack,
  output logic                    cpu_int_req,
  output logic [VEC_W-1:0]        cpu_int_vector
);

  localparam int unsigned IDX_W = (NDEV > 1) ? $clog2(NDEV) : 1;

  int_state_t          state;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    win_idx;
  logic [VEC_W-1:0]    win_vec;
  logic                found;

  // Lowest set index wins.
  always_comb begin
    win_idx = '0;
    win_vec = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (dev_interrupt[i] && !found) begin
        win_idx = IDX_W'(i);
        win_vec = dev_vector[VEC_W*i +: VEC_W];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= INT_IDLE;
      winner            <= '0;
      dev_interrupt_ack <= '0;
      cpu_int_req       <= 1'b0;
      cpu_int_vector    <= '0;
    end else begin
      case (state)
        INT_IDLE: begin
          dev_interrupt_ack <= '0;
          if (found) begin
            winner         <= win_idx;
            cpu_int_vector <= win_vec;
            cpu_int_req    <= 1'b1;
            state          <= INT_PEND;
          end
        end
        INT_PEND: begin
          // Ack takes precedence over a same-clock withdrawal.
          if (cpu_int_ack) begin
            cpu_int_req       <= 1'b0;
            dev_interrupt_ack <= NDEV'(1) << winner;
            state             <= INT_ACK;
          end else if (!dev_interrupt[winner]) begin
            cpu_int_req <= 1'b0;
            state       <= INT_IDLE;
          end
        end
        INT_ACK: begin
          dev_interrupt_ack <= '0;
          state             <= INT_IDLE;
        end
        default: begin
          dev_interrupt_ack <= '0;
          cpu_int_req       <= 1'b0;
          state             <= INT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/iopage_ctl.sv
// CPU-side I/O-page bus initiator with NXM timeout, plus the interrupt arbiter.
module iopage_ctl
  import iopage_ctl_pkg::*;
#(
  parameter int unsigned NDEV       = 4,
  parameter int unsigned NXM_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_data_in,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic                    cpu_byte_op,
  output logic [DATA_W-1:0]       cpu_data_out,
  output logic                    cpu_done,
  output logic                    cpu_nxm,
  output logic                    cpu_busy,
  output logic [ADDR_W-1:0]       iopage_addr,
  output logic [DATA_W-1:0]       data_out,
  output logic                    iopage_rd,
  output logic                    iopage_wr,
  output logic                    iopage_byte_op,
  input  logic [NDEV-1:0]         dev_decode,
  input  logic [DATA_W*NDEV-1:0]  dev_data_in,
  input  logic [NDEV-1:0]         dev_interrupt,
  input  logic [VEC_W*NDEV-1:0]   dev_vector,
  output logic [NDEV-1:0]         dev_interrupt_ack,
  output logic                    cpu_int_req,
  output logic [VEC_W-1:0]        cpu_int_vector,
  input  logic                    cpu_int_ack
);

  bus_state_t          state;
  logic                is_wr;
  logic [CNT_W-1:0]    wait_cnt;
  logic [DATA_W-1:0]   sel_data;
  logic                claimed;

  // Read data comes from the lowest-index device that claims the address.
  always_comb begin
    sel_data = '0;
    claimed  = 1'b0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (dev_decode[i] && !claimed) begin
        sel_data = dev_data_in[DATA_W*i +: DATA_W];
        claimed  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BUS_IDLE;
      is_wr          <= 1'b0;
      wait_cnt       <= '0;
      cpu_data_out   <= '0;
      cpu_done       <= 1'b0;
      cpu_nxm        <= 1'b0;
      cpu_busy       <= 1'b0;
      iopage_addr    <= '0;
      data_out       <= '0;
      iopage_rd      <= 1'b0;
      iopage_wr      <= 1'b0;
      iopage_byte_op <= 1'b0;
    end else begin
      case (state)
        BUS_IDLE: begin
          cpu_done     <= 1'b0;
          cpu_nxm      <= 1'b0;
          cpu_data_out <= '0;
          // A simultaneous read and write request performs the write.
          if (cpu_rd || cpu_wr) begin
            iopage_addr    <= cpu_addr;
            data_out       <= cpu_data_in;
            iopage_byte_op <= cpu_byte_op;
            is_wr          <= cpu_wr;
            iopage_wr      <= cpu_wr;
            iopage_rd      <= !cpu_wr;
            wait_cnt       <= '0;
            cpu_busy       <= 1'b1;
            state          <= BUS_STROBE;
          end
        end
        BUS_STROBE: begin
          if (claimed) begin
            iopage_rd    <= 1'b0;
            iopage_wr    <= 1'b0;
            cpu_done     <= 1'b1;
            cpu_data_out <= is_wr ? '0 : steer_rd(sel_data, iopage_byte_op, iopage_addr[0]);
            state        <= BUS_DONE;
          end else if (wait_cnt == CNT_W'(NXM_CYCLES - 1)) begin
            iopage_rd    <= 1'b0;
            iopage_wr    <= 1'b0;
            cpu_nxm      <= 1'b1;
            cpu_data_out <= '0;
            state        <= BUS_NXM;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        BUS_DONE, BUS_NXM: begin
          cpu_done     <= 1'b0;
          cpu_nxm      <= 1'b0;
          cpu_data_out <= '0;
          cpu_busy     <= 1'b0;
          state        <= BUS_IDLE;
        end
        default: begin
          iopage_rd <= 1'b0;
          iopage_wr <= 1'b0;
          cpu_busy  <= 1'b0;
          state     <= BUS_IDLE;
        end
      endcase
    end
  end

  iopage_int_arb #(
    .NDEV (NDEV)
  ) u_int_arb (
    .clk               (clk),
    .reset             (reset),
    .dev_interrupt     (dev_interrupt),
    .dev_vector        (dev_vector),
    .cpu_int_ack       (cpu_int_ack),
    .dev_interrupt_ack (dev_interrupt_ack),
    .cpu_int_req       (cpu_int_req),
    .cpu_int_vector    (cpu_int_vector)
  );

endmodule

// File: tb/tb_iopage_ctl.sv
// Directed bench for iopage_ctl: bus transaction table plus interrupt and reset sequences.
module tb_iopage_ctl;

  localparam int unsigned NDEV = 4;
  localparam int unsigned NXM  = 8;

  logic          clk;
  logic          reset;
  logic [12:0]   cpu_addr;
  logic [15:0]   cpu_data_in;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          cpu_byte_op;
  logic [15:0]   cpu_data_out;
  logic          cpu_done;
  logic          cpu_nxm;
  logic          cpu_busy;
  logic [12:0]   iopage_addr;
  logic [15:0]   data_out;
  logic          iopage_rd;
  logic          iopage_wr;
  logic          iopage_byte_op;
  logic [3:0]    dev_decode;
  logic [63:0]   dev_data_in;
  logic [3:0]    dev_interrupt;
  logic [31:0]   dev_vector;
  logic [3:0]    dev_interrupt_ack;
  logic          cpu_int_req;
  logic [7:0]    cpu_int_vector;
  logic          cpu_int_ack;

  int checks = 0;
  int errors = 0;

  iopage_ctl #(.NDEV(NDEV), .NXM_CYCLES(NXM)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_addr          (cpu_addr),
    .cpu_data_in       (cpu_data_in),
    .cpu_rd            (cpu_rd),
    .cpu_wr            (cpu_wr),
    .cpu_byte_op       (cpu_byte_op),
    .cpu_data_out      (cpu_data_out),
    .cpu_done          (cpu_done),
    .cpu_nxm           (cpu_nxm),
    .cpu_busy          (cpu_busy),
    .iopage_addr       (iopage_addr),
    .data_out          (data_out),
    .iopage_rd         (iopage_rd),
    .iopage_wr         (iopage_wr),
    .iopage_byte_op    (iopage_byte_op),
    .dev_decode        (dev_decode),
    .dev_data_in       (dev_data_in),
    .dev_interrupt     (dev_interrupt),
    .dev_vector        (dev_vector),
    .dev_interrupt_ack (dev_interrupt_ack),
    .cpu_int_req       (cpu_int_req),
    .cpu_int_vector    (cpu_int_vector),
    .cpu_int_ack       (cpu_int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        byte_op;
    logic [3:0]  decode;
    logic [63:0] dev_data;
    logic        exp_wr;
    logic        exp_done;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to its done/NXM pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int strobes;
    dev_decode  = v.decode;
    dev_data_in = v.dev_data;
    cpu_addr    = v.addr;
    cpu_data_in = v.wdata;
    cpu_byte_op = v.byte_op;
    cpu_rd      = v.rd;
    cpu_wr      = v.wr;
    step();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    chk($sformatf("v%0d_iopage_wr", idx), 64'(iopage_wr), 64'(v.exp_wr));
    chk($sformatf("v%0d_iopage_rd", idx), 64'(iopage_rd), 64'(!v.exp_wr));
    chk($sformatf("v%0d_addr", idx), 64'(iopage_addr), 64'(v.addr));
    chk($sformatf("v%0d_data_out", idx), 64'(data_out), 64'(v.wdata));
    chk($sformatf("v%0d_byte_op", idx), 64'(iopage_byte_op), 64'(v.byte_op));
    chk($sformatf("v%0d_busy", idx), 64'(cpu_busy), 64'(1));
    lat = 1;
    strobes = (iopage_rd || iopage_wr) ? 1 : 0;
    while (!(cpu_done || cpu_nxm) && lat < 40) begin
      step();
      lat++;
      if (iopage_rd || iopage_wr) strobes++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_strobe_clocks", idx), 64'(strobes), 64'(v.exp_lat - 1));
    chk($sformatf("v%0d_done", idx), 64'(cpu_done), 64'(v.exp_done));
    chk($sformatf("v%0d_nxm", idx), 64'(cpu_nxm), 64'(!v.exp_done));
    chk($sformatf("v%0d_rdata", idx), 64'(cpu_data_out), 64'(v.exp_rdata));
    step();
    chk($sformatf("v%0d_pulse_end", idx), 64'({cpu_done, cpu_nxm, cpu_busy}), 64'(0));
    dev_decode = '0;
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0] = '{1'b0, 1'b1, 13'o17546, 16'o000100, 1'b0, 4'b0010,
                64'h0000_0000_FFFF_0000, 1'b1, 1'b1, 16'h0000, 2};
    vecs[1] = '{1'b1, 1'b0, 13'o17546, 16'h0000, 1'b0, 4'b0100,
                64'h0000_00C0_0000_0000, 1'b0, 1'b1, 16'h00C0, 2};
    vecs[2] = '{1'b1, 1'b0, 13'o17547, 16'h0000, 1'b1, 4'b0001,
                64'h0000_0000_0000_A55A, 1'b0, 1'b1, 16'h00A5, 2};
    vecs[3] = '{1'b1, 1'b0, 13'o17546, 16'h0000, 1'b1, 4'b0001,
                64'h0000_0000_0000_A55A, 1'b0, 1'b1, 16'h005A, 2};
    vecs[4] = '{1'b1, 1'b0, 13'o17520, 16'h0000, 1'b0, 4'b1010,
                64'h3333_2222_1111_0000, 1'b0, 1'b1, 16'h1111, 2};
    vecs[5] = '{1'b0, 1'b1, 13'o17521, 16'h00EE, 1'b1, 4'b1000,
                64'h3333_0000_0000_0000, 1'b1, 1'b1, 16'h0000, 2};
    vecs[6] = '{1'b1, 1'b0, 13'o17000, 16'h0000, 1'b0, 4'b0000,
                64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 16'h0000, NXM + 1};
    vecs[7] = '{1'b0, 1'b1, 13'o17002, 16'hBEEF, 1'b0, 4'b0000,
                64'h0, 1'b1, 1'b0, 16'h0000, NXM + 1};
    vecs[8] = '{1'b1, 1'b1, 13'o17404, 16'h5A5A, 1'b0, 4'b0100,
                64'h0000_7777_0000_0000, 1'b1, 1'b1, 16'h0000, 2};

    reset = 1'b1;
    cpu_addr = '0; cpu_data_in = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
    dev_decode = '0; dev_data_in = '0; dev_interrupt = '0; cpu_int_ack = 1'b0;
    dev_vector = {8'h40, 8'h22, 8'h40, 8'h11};
    step();
    step();
    chk("reset_outputs", 64'({cpu_done, cpu_nxm, cpu_busy, iopage_rd, iopage_wr, iopage_byte_op,
                              cpu_int_req, dev_interrupt_ack}), 64'(0));
    chk("reset_buses", 64'({iopage_addr, data_out, cpu_data_out, cpu_int_vector}), 64'(0));
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      step();
    end

    // NXM read with a second request dropped while busy.
    cpu_addr = 13'o17000; cpu_rd = 1'b1; cpu_byte_op = 1'b0;
    step();
    cpu_rd = 1'b0;
    step(); step(); step();
    cpu_addr = 13'o00010; cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    chk("busy_drop_addr", 64'(iopage_addr), 64'(13'o17000));
    lat = 5;
    while (!cpu_nxm && lat < 40) begin
      step();
      lat++;
    end
    chk("busy_drop_nxm_latency", 64'(lat), 64'(NXM + 1));
    step();
    step();
    chk("busy_drop_no_replay", 64'({iopage_rd, iopage_wr, cpu_busy}), 64'(0));

    // Interrupt: dev1 and dev3 pending; dev1 wins.
    dev_interrupt = 4'b1010;
    step();
    chk("int_req", 64'(cpu_int_req), 64'(1));
    chk("int_vector_dev1", 64'(cpu_int_vector), 64'(8'h40));
    dev_interrupt = 4'b1011;
    step();
    chk("int_no_rearb", 64'({cpu_int_req, cpu_int_vector}), 64'({1'b1, 8'h40}));
    dev_interrupt = 4'b1010;
    cpu_int_ack = 1'b1;
    step();
    cpu_int_ack = 1'b0;
    chk("int_ack_dev1", 64'(dev_interrupt_ack), 64'(4'b0010));
    chk("int_req_low_in_ack", 64'(cpu_int_req), 64'(0));
    dev_interrupt = 4'b1000;
    step();
    chk("int_ack_one_clock", 64'({dev_interrupt_ack, cpu_int_req}), 64'(0));
    step();
    chk("int_dev3_granted", 64'({cpu_int_req, cpu_int_vector}), 64'({1'b1, 8'h40}));
    cpu_int_ack = 1'b1;
    step();
    cpu_int_ack = 1'b0;
    chk("int_ack_dev3", 64'(dev_interrupt_ack), 64'(4'b1000));
    dev_interrupt = '0;
    step();
    step();
    chk("int_idle_after", 64'({dev_interrupt_ack, cpu_int_req}), 64'(0));

    // Withdrawal without ack.
    dev_interrupt = 4'b0100;
    step();
    chk("wd_req_vector", 64'({cpu_int_req, cpu_int_vector}), 64'({1'b1, 8'h22}));
    dev_interrupt = '0;
    step();
    chk("wd_req_falls", 64'({cpu_int_req, dev_interrupt_ack}), 64'(0));
    step();
    chk("wd_no_ack", 64'({cpu_int_req, dev_interrupt_ack}), 64'(0));

    // Ack and withdrawal in the same clock: ack wins.
    dev_interrupt = 4'b0001;
    step();
    chk("race_vector", 64'({cpu_int_req, cpu_int_vector}), 64'({1'b1, 8'h11}));
    dev_interrupt = '0;
    cpu_int_ack = 1'b1;
    step();
    cpu_int_ack = 1'b0;
    chk("race_ack_wins", 64'(dev_interrupt_ack), 64'(4'b0001));
    step();
    step();

    // Reset mid-STROBE and mid-PEND.
    cpu_addr = 13'o17000; cpu_data_in = 16'h1357; cpu_wr = 1'b1;
    dev_interrupt = 4'b0100;
    step();
    cpu_wr = 1'b0;
    step();
    chk("pre_reset_active", 64'({iopage_wr, cpu_busy, cpu_int_req}), 64'(3'b111));
    reset = 1'b1;
    step();
    chk("mid_reset_outputs", 64'({cpu_done, cpu_nxm, cpu_busy, iopage_rd, iopage_wr,
                                  iopage_byte_op, cpu_int_req, dev_interrupt_ack}), 64'(0));
    chk("mid_reset_buses", 64'({iopage_addr, data_out, cpu_data_out, cpu_int_vector}), 64'(0));
    reset = 1'b0;
    dev_interrupt = '0;
    pulses = 0;
    for (int i = 0; i < NXM + 4; i++) begin
      step();
      if (cpu_done || cpu_nxm || iopage_wr || (dev_interrupt_ack != 0)) pulses++;
    end
    chk("no_pulse_after_abort", 64'(pulses), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
